// File: rtl/svm_operand_seq.sv
// svm_operand_seq: operand sequencer feeding the SVM dot-product multiplier.
// On start it walks every support vector against the feature vector, pairing
// feature word f with SV word (s*num_feat + f) read from two synchronous RAMs,
// and presents the pairs to the multiplier through a 2-entry operand buffer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, num_feat, num_sv    run request and configuration (sampled in IDLE)
//   busy, done                 run in progress / one-cycle completion pulse
//   feat_rd_en/addr/rdata      feature RAM read port (1-cycle latency)
//   sv_rd_en/addr/rdata        SV RAM read port (1-cycle latency)
//   data_1, data_2, mult_en    operand pair and valid to the multiplier
//   dn_ready                   downstream accept (transfer = mult_en & dn_ready)
//   mult_op_sel, vec_last      first / last pair of the current SV
//   sv_idx                     SV index of the presented pair
module svm_operand_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FEAT_AW    = 6,
  parameter int unsigned SV_AW      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FEAT_AW:0]      num_feat,
  input  logic [7:0]            num_sv,
  output logic                  busy,
  output logic                  done,
  output logic                  feat_rd_en,
  output logic [FEAT_AW-1:0]    feat_addr,
  input  logic [DATA_WIDTH-1:0] feat_rdata,
  output logic                  sv_rd_en,
  output logic [SV_AW-1:0]      sv_addr,
  input  logic [DATA_WIDTH-1:0] sv_rdata,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] data_2,
  output logic                  mult_en,
  input  logic                  dn_ready,
  output logic                  mult_op_sel,
  output logic                  vec_last,
  output logic [7:0]            sv_idx
);

  localparam int unsigned NF_W  = FEAT_AW + 1;
  localparam int unsigned ENT_W = 2 * DATA_WIDTH + 10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [NF_W-1:0]  cfg_nf, f_cnt, eff_nf, eff_f;
  logic [7:0]       cfg_ns, s_cnt, eff_ns, eff_s;
  logic [SV_AW-1:0] lin, eff_lin;
  logic             rd_en, rd_first, rd_last;
  logic [7:0]       rd_idx;
  logic             inf_valid, inf_first, inf_last;
  logic [7:0]       inf_idx;
  logic [ENT_W-1:0] ent0, ent1, ent0_nxt, ent1_nxt, arr, head, l0, l1;
  logic [1:0]       cnt, cnt_nxt;
  logic             idle, go, go_zero, pop, room, issue, f_last, elem_last, drained;

  // Buffer view: stored entries first, then the word arriving from the RAMs.
  // The arriving word can be the head directly so a pair reaches the
  // multiplier the cycle its RAM data becomes valid.
  always_comb begin
    pop      = mult_en & dn_ready;
    arr      = {feat_rdata, sv_rdata, inf_first, inf_last, inf_idx};
    l0       = (cnt != 2'd0) ? ent0 : arr;
    l1       = (cnt == 2'd2) ? ent1 : arr;
    ent0_nxt = pop ? l1 : l0;
    ent1_nxt = l1;
    cnt_nxt  = cnt + 2'(inf_valid) - 2'(pop);
    head     = (cnt != 2'd0) ? ent0 : (inf_valid ? arr : '0);
  end

  assign mult_en     = (cnt != 2'd0) | inf_valid;
  assign data_1      = head[ENT_W-1 -: DATA_WIDTH];
  assign data_2      = head[ENT_W-DATA_WIDTH-1 -: DATA_WIDTH];
  assign mult_op_sel = head[9];
  assign vec_last    = head[8];
  assign sv_idx      = head[7:0];
  assign feat_rd_en  = rd_en;
  assign sv_rd_en    = rd_en;
  assign busy        = (state == S_FETCH) | (state == S_DRAIN);
  assign done        = (state == S_DONE);

  // Read scheduling; in IDLE the first element is addressed from the inputs
  // so the first read goes out the cycle after start.
  always_comb begin
    idle      = (state == S_IDLE);
    eff_nf    = idle ? num_feat : cfg_nf;
    eff_ns    = idle ? num_sv : cfg_ns;
    eff_f     = idle ? '0 : f_cnt;
    eff_s     = idle ? '0 : s_cnt;
    eff_lin   = idle ? '0 : lin;
    go        = idle & start & (num_feat != '0) & (num_sv != 8'd0);
    go_zero   = idle & start & ((num_feat == '0) | (num_sv == 8'd0));
    // Counts the read now on the bus as already buffered, assuming no pop.
    room      = (cnt_nxt + 2'(rd_en)) < 2'd2;
    issue     = go | ((state == S_FETCH) & room);
    f_last    = (eff_f == eff_nf - NF_W'(1));
    elem_last = f_last & (eff_s == eff_ns - 8'd1);
    drained   = (cnt_nxt == 2'd0) & ~rd_en;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go)           state_nxt = elem_last ? S_DRAIN : S_FETCH;
        else if (go_zero) state_nxt = S_DONE;
      end
      S_FETCH: if (issue && elem_last) state_nxt = S_DRAIN;
      S_DRAIN: if (drained) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Counters, read port, in-flight tag and operand buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_nf    <= '0;
      cfg_ns    <= '0;
      f_cnt     <= '0;
      s_cnt     <= '0;
      lin       <= '0;
      rd_en     <= 1'b0;
      rd_first  <= 1'b0;
      rd_last   <= 1'b0;
      rd_idx    <= '0;
      feat_addr <= '0;
      sv_addr   <= '0;
      inf_valid <= 1'b0;
      inf_first <= 1'b0;
      inf_last  <= 1'b0;
      inf_idx   <= '0;
      ent0      <= '0;
      ent1      <= '0;
      cnt       <= '0;
    end else begin
      cnt       <= cnt_nxt;
      ent0      <= ent0_nxt;
      ent1      <= ent1_nxt;
      inf_valid <= rd_en;
      inf_first <= rd_first;
      inf_last  <= rd_last;
      inf_idx   <= rd_idx;
      rd_en     <= issue;
      if (go) begin
        cfg_nf <= num_feat;
        cfg_ns <= num_sv;
      end
      if (issue) begin
        feat_addr <= eff_f[FEAT_AW-1:0];
        sv_addr   <= eff_lin;
        rd_first  <= (eff_f == '0);
        rd_last   <= f_last;
        rd_idx    <= eff_s;
        f_cnt     <= f_last ? '0 : eff_f + NF_W'(1);
        s_cnt     <= f_last ? eff_s + 8'd1 : eff_s;
        lin       <= eff_lin + SV_AW'(1);
      end
    end
  end

endmodule
